// File: rtl/pcpu_run_ctrl.sv
// Host-side run controller for the PCPU core: host command decode, memory
// preload/readback, CPU run sequencing, cycle counting and completion report.
module pcpu_run_ctrl #(
  parameter logic [4:0]  HALT_OP    = 5'b00001,
  parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        h_valid,
  output logic        h_ready,
  input  logic [1:0]  h_cmd,
  input  logic [7:0]  h_addr,
  input  logic [15:0] h_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic [1:0]  rsp_status,
  output logic        cpu_reset,
  output logic        cpu_enable,
  output logic        cpu_start,
  input  logic [15:0] cpu_wb_ir,
  input  logic [7:0]  cpu_i_addr,
  input  logic [7:0]  cpu_d_addr,
  input  logic        cpu_d_we,
  input  logic [15:0] cpu_d_dataout,
  output logic [7:0]  im_addr,
  output logic        im_we,
  output logic [15:0] im_wdata,
  output logic [7:0]  dm_addr,
  output logic        dm_we,
  output logic [15:0] dm_wdata,
  input  logic [15:0] dm_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_RST   = 3'd3,
    S_START = 3'd4,
    S_RUN   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_HALT    = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  state_t      state_r, state_s;
  logic        h_ready_r, h_ready_s;
  logic        rsp_valid_r, rsp_valid_s;
  logic [15:0] rsp_data_r, rsp_data_s;
  logic [1:0]  rsp_status_r, rsp_status_s;
  logic        cpu_reset_r, cpu_reset_s;
  logic        cpu_enable_r, cpu_enable_s;
  logic        cpu_start_r, cpu_start_s;
  logic        im_we_r, im_we_s;
  logic        dm_we_r, dm_we_s;
  logic [7:0]  cmd_addr_r, cmd_addr_s;
  logic [15:0] cmd_wdata_r, cmd_wdata_s;
  logic [15:0] cnt_r, cnt_s;
  logic        run_mux_r, run_mux_s;
  logic        halt_s;

  assign halt_s = (cpu_wb_ir[15:11] == HALT_OP);

  // Next-state and next-output decode; every output register is loaded from here.
  always_comb begin
    state_s      = state_r;
    rsp_valid_s  = 1'b0;
    rsp_data_s   = rsp_data_r;
    rsp_status_s = rsp_status_r;
    cpu_reset_s  = 1'b0;
    cpu_start_s  = 1'b0;
    im_we_s      = 1'b0;
    dm_we_s      = 1'b0;
    cmd_addr_s   = cmd_addr_r;
    cmd_wdata_s  = cmd_wdata_r;
    cnt_s        = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (h_valid) begin
          cmd_addr_s  = h_addr;
          cmd_wdata_s = h_wdata;
          case (h_cmd)
            2'd0, 2'd1: begin
              // Write strobe and its OK response share the single WRITE cycle.
              state_s      = S_WRITE;
              im_we_s      = (h_cmd == 2'd0);
              dm_we_s      = (h_cmd == 2'd1);
              rsp_valid_s  = 1'b1;
              rsp_data_s   = 16'd0;
              rsp_status_s = ST_OK;
            end
            2'd2: begin
              state_s = S_READ;
            end
            2'd3: begin
              state_s     = S_RST;
              cpu_reset_s = 1'b1;
              cnt_s       = 16'd0;
            end
            default: begin
              state_s = S_IDLE;
            end
          endcase
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WRITE: begin
        state_s = S_IDLE;
      end
      S_READ: begin
        state_s      = S_DONE;
        rsp_valid_s  = 1'b1;
        rsp_data_s   = dm_rdata;
        rsp_status_s = ST_OK;
      end
      S_RST: begin
        state_s     = S_START;
        cpu_start_s = 1'b1;
        cnt_s       = 16'd1;
      end
      S_START, S_RUN: begin
        // The counter already includes the current enabled cycle; HALT wins over timeout.
        if (halt_s) begin
          state_s      = S_DONE;
          rsp_valid_s  = 1'b1;
          rsp_data_s   = cnt_r;
          rsp_status_s = ST_HALT;
        end else if (cnt_r == MAX_CYCLES) begin
          state_s      = S_DONE;
          rsp_valid_s  = 1'b1;
          rsp_data_s   = cnt_r;
          rsp_status_s = ST_TIMEOUT;
        end else begin
          state_s = S_RUN;
          cnt_s   = (cnt_r == 16'hFFFF) ? cnt_r : (cnt_r + 16'd1);
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    h_ready_s    = (state_s == S_IDLE);
    cpu_enable_s = (state_s == S_START) || (state_s == S_RUN);
    run_mux_s    = cpu_enable_s;
  end

  // State and registered-output update with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= S_IDLE;
      h_ready_r    <= 1'b1;
      rsp_valid_r  <= 1'b0;
      rsp_data_r   <= 16'd0;
      rsp_status_r <= 2'd0;
      cpu_reset_r  <= 1'b0;
      cpu_enable_r <= 1'b0;
      cpu_start_r  <= 1'b0;
      im_we_r      <= 1'b0;
      dm_we_r      <= 1'b0;
      cmd_addr_r   <= 8'd0;
      cmd_wdata_r  <= 16'd0;
      cnt_r        <= 16'd0;
      run_mux_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      h_ready_r    <= h_ready_s;
      rsp_valid_r  <= rsp_valid_s;
      rsp_data_r   <= rsp_data_s;
      rsp_status_r <= rsp_status_s;
      cpu_reset_r  <= cpu_reset_s;
      cpu_enable_r <= cpu_enable_s;
      cpu_start_r  <= cpu_start_s;
      im_we_r      <= im_we_s;
      dm_we_r      <= dm_we_s;
      cmd_addr_r   <= cmd_addr_s;
      cmd_wdata_r  <= cmd_wdata_s;
      cnt_r        <= cnt_s;
      run_mux_r    <= run_mux_s;
    end
  end

  assign h_ready    = h_ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rsp_data_r;
  assign rsp_status = rsp_status_r;
  assign cpu_reset  = cpu_reset_r;
  assign cpu_enable = cpu_enable_r;
  assign cpu_start  = cpu_start_r;

  // While the core runs it owns the memory ports; otherwise the command register does.
  assign im_addr  = run_mux_r ? cpu_i_addr    : cmd_addr_r;
  assign im_we    = im_we_r;
  assign im_wdata = cmd_wdata_r;
  assign dm_addr  = run_mux_r ? cpu_d_addr    : cmd_addr_r;
  assign dm_we    = run_mux_r ? cpu_d_we      : dm_we_r;
  assign dm_wdata = run_mux_r ? cpu_d_dataout : cmd_wdata_r;

endmodule
